// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin byte-serial sequencer sharing the RAM/IO port between fetch and load/store
module mem_arbiter #(
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        roll_back,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        IF_req,
    input  logic [31:0] IF_addr,
    output logic        IF_done,
    output logic [31:0] IF_data,
    input  logic        LSB_req,
    input  logic        LSB_is_store,
    input  logic [31:0] LSB_addr,
    input  logic [1:0]  LSB_size,
    input  logic [31:0] LSB_wdata,
    output logic        LSB_done,
    output logic [31:0] LSB_rdata
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rbuf;
    logic [2:0]  cnt;
    logic [2:0]  len;
    logic        owner_lsb;
    logic        last_lsb;

    logic        grant_if;
    logic        grant_lsb;
    logic [31:0] sel_addr;
    logic [2:0]  lsb_len;
    logic        sel_stall;
    logic        io_stall;
    logic [2:0]  cnt_inc;
    logic [2:0]  wr_next;
    logic [1:0]  byte_idx;
    logic [7:0]  wr_byte;
    logic [31:0] rbuf_nxt;

    assign grant_if  = IF_req && (!LSB_req || last_lsb);
    assign grant_lsb = LSB_req && !grant_if;
    assign sel_addr  = grant_if ? IF_addr : LSB_addr;
    assign lsb_len   = LSB_size == 2'd0 ? 3'd1 : LSB_size == 2'd1 ? 3'd2 : 3'd4;
    assign sel_stall = io_buffer_full && LSB_addr[17:16] == IO_ADDR_HI;
    assign io_stall  = io_buffer_full && addr[17:16] == IO_ADDR_HI;
    assign cnt_inc   = cnt + 3'd1;
    assign wr_next   = mem_wr ? cnt_inc : cnt;
    assign byte_idx  = cnt[1:0] - 2'd1;
    assign wr_byte   = wdata[{wr_next[1:0], 3'b000} +: 8];

    // merge the byte arriving this cycle (address issued two edges ago) into the read buffer
    always_comb begin
        rbuf_nxt = rbuf;
        if (cnt != 3'd0) rbuf_nxt[{byte_idx, 3'b000} +: 8] = mem_din;
    end

    // arbitration and byte-serial transfer state machine with registered port outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr      <= '0;
            wdata     <= '0;
            rbuf      <= '0;
            cnt       <= '0;
            len       <= '0;
            owner_lsb <= 1'b0;
            last_lsb  <= 1'b0;
            mem_a     <= '0;
            mem_dout  <= '0;
            mem_wr    <= 1'b0;
            IF_done   <= 1'b0;
            LSB_done  <= 1'b0;
            IF_data   <= '0;
            LSB_rdata <= '0;
        end else if (rdy) begin
            IF_done  <= 1'b0;
            LSB_done <= 1'b0;
            case (state)
                IDLE: begin
                    mem_wr <= 1'b0;
                    if (grant_if || grant_lsb) begin
                        addr      <= sel_addr;
                        mem_a     <= sel_addr;
                        len       <= grant_if ? 3'd4 : lsb_len;
                        wdata     <= LSB_wdata;
                        owner_lsb <= grant_lsb;
                        last_lsb  <= grant_lsb;
                        cnt       <= '0;
                        rbuf      <= '0;
                        if (grant_lsb && LSB_is_store) begin
                            state    <= WRITE;
                            mem_wr   <= !sel_stall;
                            mem_dout <= LSB_wdata[7:0];
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    mem_wr <= 1'b0;
                    if (roll_back) begin
                        state <= IDLE;
                    end else begin
                        cnt  <= cnt_inc;
                        rbuf <= rbuf_nxt;
                        if (cnt_inc < len) mem_a <= addr + {29'b0, cnt_inc};
                        if (cnt == len) begin
                            state <= DONE;
                            if (owner_lsb) begin
                                LSB_done  <= 1'b1;
                                LSB_rdata <= rbuf_nxt;
                            end else begin
                                IF_done <= 1'b1;
                                IF_data <= rbuf_nxt;
                            end
                        end
                    end
                end
                WRITE: begin
                    cnt <= wr_next;
                    if (wr_next == len) begin
                        state    <= DONE;
                        mem_wr   <= 1'b0;
                        LSB_done <= 1'b1;
                    end else begin
                        mem_wr   <= !io_stall;
                        mem_a    <= addr + {29'b0, wr_next};
                        mem_dout <= wr_byte;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_wr <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario tests for mem_arbiter against a synchronous byte RAM model
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        roll_back = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        IF_req = 1'b0;
    logic [31:0] IF_addr = '0;
    logic        IF_done;
    logic [31:0] IF_data;
    logic        LSB_req = 1'b0;
    logic        LSB_is_store = 1'b0;
    logic [31:0] LSB_addr = '0;
    logic [1:0]  LSB_size = '0;
    logic [31:0] LSB_wdata = '0;
    logic        LSB_done;
    logic [31:0] LSB_rdata;

    int errors = 0;
    int checks = 0;
    logic [7:0] ram [0:65535];

    mem_arbiter #(.IO_ADDR_HI(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .roll_back(roll_back),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .IF_req(IF_req), .IF_addr(IF_addr),
        .IF_done(IF_done), .IF_data(IF_data), .LSB_req(LSB_req),
        .LSB_is_store(LSB_is_store), .LSB_addr(LSB_addr), .LSB_size(LSB_size),
        .LSB_wdata(LSB_wdata), .LSB_done(LSB_done), .LSB_rdata(LSB_rdata)
    );

    always #5 clk = ~clk;

    // synchronous RAM: read data appears the cycle after its address
    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
        mem_din <= ram[mem_a[15:0]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        cyc(2);
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset mem_a: got %h expected 0", mem_a); end
        checks++; if (mem_dout !== 8'h0) begin errors++; $display("FAIL reset mem_dout: got %h expected 0", mem_dout); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset mem_wr: got %b expected 0", mem_wr); end
        checks++; if ({IF_done, LSB_done} !== 2'b00) begin errors++; $display("FAIL reset done: got %b expected 00", {IF_done, LSB_done}); end
        checks++; if (IF_data !== 32'h0 || LSB_rdata !== 32'h0) begin errors++; $display("FAIL reset data: got %h/%h expected 0/0", IF_data, LSB_rdata); end
        rst = 1'b1;
        cyc(1);
    endtask

    task automatic test_alternate;
        int got = 0;
        logic order [4];
        IF_req = 1'b1; IF_addr = 32'h100;
        LSB_req = 1'b1; LSB_is_store = 1'b0; LSB_addr = 32'h600; LSB_size = 2'd0;
        cyc(1);
        checks++; if (mem_a !== 32'h600) begin errors++; $display("FAIL first_grant mem_a: got %h expected 00000600", mem_a); end
        for (int t = 0; t < 80 && got < 4; t++) begin
            cyc(1);
            if (LSB_done) begin
                order[got] = 1'b1; got++;
                checks++; if (LSB_rdata !== 32'h000000A5) begin errors++; $display("FAIL alt lsb_rdata: got %h expected 000000a5", LSB_rdata); end
            end
            if (IF_done) begin
                order[got] = 1'b0; got++;
                checks++; if (IF_data !== 32'h00000013) begin errors++; $display("FAIL alt if_data: got %h expected 00000013", IF_data); end
            end
            if (got == 4) begin IF_req = 1'b0; LSB_req = 1'b0; end
        end
        IF_req = 1'b0; LSB_req = 1'b0;
        checks++; if (got !== 4) begin errors++; $display("FAIL alt done_count: got %0d expected 4", got); end
        for (int i = 0; i < got; i++) begin
            checks++; if (order[i] !== (i % 2 == 0)) begin errors++; $display("FAIL alt order[%0d]: got lsb=%b expected lsb=%b", i, order[i], i % 2 == 0); end
        end
        cyc(3);
    endtask

    task automatic test_fetch;
        IF_req = 1'b1; IF_addr = 32'h100;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            if (k < 4) begin
                checks++; if (mem_a !== 32'h100 + k) begin errors++; $display("FAIL fetch mem_a c%0d: got %h expected %h", k, mem_a, 32'h100 + k); end
                checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL fetch mem_wr c%0d: got %b expected 0", k, mem_wr); end
            end
            checks++; if (IF_done !== (k == 5)) begin errors++; $display("FAIL fetch IF_done c%0d: got %b expected %b", k, IF_done, k == 5); end
        end
        checks++; if (IF_data !== 32'h00000013) begin errors++; $display("FAIL fetch IF_data: got %h expected 00000013", IF_data); end
        IF_req = 1'b0;
        cyc(1);
        checks++; if (IF_done !== 1'b0) begin errors++; $display("FAIL fetch done_width: got %b expected 0", IF_done); end
        cyc(1);
    endtask

    task automatic test_store_wrap;
        LSB_req = 1'b1; LSB_is_store = 1'b1; LSB_addr = 32'hFFFFFFFF; LSB_size = 2'd1; LSB_wdata = 32'hCAFEBEEF;
        cyc(1);
        checks++; if ({mem_wr, mem_a, mem_dout, LSB_done} !== {1'b1, 32'hFFFFFFFF, 8'hEF, 1'b0}) begin errors++; $display("FAIL wrap c0: got wr=%b a=%h d=%h done=%b expected wr=1 a=ffffffff d=ef done=0", mem_wr, mem_a, mem_dout, LSB_done); end
        cyc(1);
        checks++; if ({mem_wr, mem_a, mem_dout, LSB_done} !== {1'b1, 32'h00000000, 8'hBE, 1'b0}) begin errors++; $display("FAIL wrap c1: got wr=%b a=%h d=%h done=%b expected wr=1 a=00000000 d=be done=0", mem_wr, mem_a, mem_dout, LSB_done); end
        cyc(1);
        checks++; if ({mem_wr, LSB_done} !== 2'b01) begin errors++; $display("FAIL wrap c2: got wr=%b done=%b expected wr=0 done=1", mem_wr, LSB_done); end
        LSB_req = 1'b0;
        cyc(2);
        checks++; if ({ram[16'hFFFF], ram[16'h0000]} !== 16'hEFBE) begin errors++; $display("FAIL wrap ram: got %h%h expected efbe", ram[16'hFFFF], ram[16'h0000]); end
    endtask

    task automatic test_io_stall;
        io_buffer_full = 1'b1;
        LSB_req = 1'b1; LSB_is_store = 1'b1; LSB_addr = 32'h00030000; LSB_size = 2'd0; LSB_wdata = 32'h0000005A;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            checks++; if ({mem_wr, LSB_done} !== 2'b00) begin errors++; $display("FAIL io_stall c%0d: got wr=%b done=%b expected wr=0 done=0", k, mem_wr, LSB_done); end
        end
        io_buffer_full = 1'b0;
        cyc(1);
        checks++; if ({mem_wr, mem_a, mem_dout, LSB_done} !== {1'b1, 32'h00030000, 8'h5A, 1'b0}) begin errors++; $display("FAIL io_release c3: got wr=%b a=%h d=%h done=%b expected wr=1 a=00030000 d=5a done=0", mem_wr, mem_a, mem_dout, LSB_done); end
        cyc(1);
        checks++; if ({mem_wr, LSB_done} !== 2'b01) begin errors++; $display("FAIL io_done c4: got wr=%b done=%b expected wr=0 done=1", mem_wr, LSB_done); end
        LSB_req = 1'b0;
        cyc(2);
    endtask

    task automatic test_rollback;
        IF_req = 1'b1; IF_addr = 32'h200;
        cyc(3);
        roll_back = 1'b1; IF_req = 1'b0;
        for (int k = 3; k < 8; k++) begin
            cyc(1);
            roll_back = 1'b0;
            checks++; if ({IF_done, mem_wr} !== 2'b00) begin errors++; $display("FAIL rb_fetch c%0d: got done=%b wr=%b expected 0 0", k, IF_done, mem_wr); end
        end
        IF_req = 1'b1; IF_addr = 32'h100;
        cyc(1);
        checks++; if (mem_a !== 32'h100) begin errors++; $display("FAIL rb_idle accept: got %h expected 00000100", mem_a); end
        cyc(5);
        checks++; if (IF_done !== 1'b1) begin errors++; $display("FAIL rb_idle done: got %b expected 1", IF_done); end
        IF_req = 1'b0;
        cyc(2);
        LSB_req = 1'b1; LSB_is_store = 1'b1; LSB_addr = 32'h40; LSB_size = 2'd2; LSB_wdata = 32'h11223344;
        cyc(2);
        roll_back = 1'b1;
        cyc(1);
        roll_back = 1'b0;
        checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h42, 8'h22}) begin errors++; $display("FAIL rb_store c2: got wr=%b a=%h d=%h expected wr=1 a=00000042 d=22", mem_wr, mem_a, mem_dout); end
        cyc(1);
        checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h43, 8'h11}) begin errors++; $display("FAIL rb_store c3: got wr=%b a=%h d=%h expected wr=1 a=00000043 d=11", mem_wr, mem_a, mem_dout); end
        cyc(1);
        checks++; if (LSB_done !== 1'b1) begin errors++; $display("FAIL rb_store done: got %b expected 1", LSB_done); end
        LSB_req = 1'b0;
        cyc(2);
    endtask

    task automatic test_async_reset;
        LSB_req = 1'b1; LSB_is_store = 1'b0; LSB_addr = 32'h300; LSB_size = 2'd2;
        cyc(3);
        #2 rst = 1'b0;
        #1;
        checks++; if ({mem_a, mem_dout, mem_wr, IF_done, LSB_done} !== 43'h0) begin errors++; $display("FAIL async_rst ctrl: got a=%h d=%h wr=%b done=%b%b expected all 0", mem_a, mem_dout, mem_wr, IF_done, LSB_done); end
        checks++; if ({IF_data, LSB_rdata} !== 64'h0) begin errors++; $display("FAIL async_rst data: got %h/%h expected 0/0", IF_data, LSB_rdata); end
        LSB_req = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(1);
    endtask

    task automatic test_rdy_stall;
        LSB_req = 1'b1; LSB_is_store = 1'b0; LSB_addr = 32'h500; LSB_size = 2'd3;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            if (k >= 5 && k <= 8) begin
                checks++; if (mem_a !== 32'h503) begin errors++; $display("FAIL rdy_hold mem_a c%0d: got %h expected 00000503", k, mem_a); end
            end
            checks++; if (LSB_done !== (k == 9)) begin errors++; $display("FAIL rdy LSB_done c%0d: got %b expected %b", k, LSB_done, k == 9); end
            if (k == 4) rdy = 1'b0;
            if (k == 8) rdy = 1'b1;
        end
        checks++; if (LSB_rdata !== 32'h12345678) begin errors++; $display("FAIL rdy LSB_rdata: got %h expected 12345678", LSB_rdata); end
        LSB_req = 1'b0;
        cyc(1);
        checks++; if (LSB_done !== 1'b0) begin errors++; $display("FAIL rdy done_width: got %b expected 0", LSB_done); end
    endtask

    initial begin
        ram[16'h0100] <= 8'h13; ram[16'h0101] <= 8'h00; ram[16'h0102] <= 8'h00; ram[16'h0103] <= 8'h00;
        ram[16'h0600] <= 8'hA5;
        ram[16'h0500] <= 8'h78; ram[16'h0501] <= 8'h56; ram[16'h0502] <= 8'h34; ram[16'h0503] <= 8'h12;
        test_reset;
        test_alternate;
        test_fetch;
        test_store_wrap;
        test_io_stall;
        test_rollback;
        test_async_reset;
        test_rdy_stall;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter for the single byte-wide RAM/IO port, shared between the instruction fetcher (front end, upstream of the instruction queue) and the load/store buffer. It accepts word fetches and byte/half/word loads and stores, splits each into serial byte transactions, reassembles read data, and returns a one-cycle completion pulse to the requester. Round-robin grant prevents fetch starvation under heavy memory traffic; ROB roll-back squashes speculative reads.

## Interface
Parameters:
- IO_ADDR_HI, 2'b11, value of addr[17:16] that marks the memory-mapped IO region.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; 0 freezes every register.
- roll_back  in  1  ROB roll-back flag.
- io_buffer_full  in  1  UART buffer full.
- mem_din  in  8  RAM/IO read byte.
- mem_dout  out  8  RAM/IO write byte.
- mem_a  out  32  RAM/IO byte address.
- mem_wr  out  1  1 = write, 0 = read.
- IF_req  in  1  fetch request, held until IF_done.
- IF_addr  in  32  fetch address.
- IF_done  out  1  one-cycle completion pulse.
- IF_data  out  32  fetched instruction, valid while IF_done=1.
- LSB_req  in  1  load/store request, held until LSB_done.
- LSB_is_store  in  1  1 = store.
- LSB_addr  in  32  access address.
- LSB_size  in  2  0 byte, 1 half, 2 or 3 word.
- LSB_wdata  in  32  store data, little-endian.
- LSB_done  out  1  one-cycle completion pulse.
- LSB_rdata  out  32  load data, zero-extended, valid while LSB_done=1.

## Operation
- States: IDLE, READ, WRITE, DONE. Reset (rst=0, async): state IDLE, mem_a=0, mem_dout=0, mem_wr=0, IF_done=0, LSB_done=0, IF_data=0, LSB_rdata=0, byte counter 0, last_grant=IF.
- IDLE: at an edge with exactly one request, grant it; with both, grant the requester not in last_grant (after reset: LSB first). Latch address, length n (IF: 4; LSB: 1/2/4), write data, owner; update last_grant. Go READ (IF or load) or WRITE (store).
- READ: mem_wr=0; mem_a = A+k for k=0..n-1 in successive cycles; byte k captured from mem_din one cycle after its address. Bytes assembled little-endian; unused upper bytes 0.
- WRITE: mem_wr=1, mem_a=A+k, mem_dout=byte k of LSB_wdata, one byte per cycle. If io_buffer_full=1 and A[17:16]==IO_ADDR_HI, hold: mem_wr=0, counter frozen, until io_buffer_full=0.
- Address arithmetic 32-bit, wraps modulo 2^32.
- DONE: owner's done=1 with data; mem_wr=0; next edge -> IDLE unconditionally. No grant taken in DONE or at the DONE->IDLE edge, so a requester dropping req after its done is never re-accepted.
- roll_back=1 at an edge: READ (fetch or load) aborts -> IDLE, no done pulse, mem_wr=0; transition into DONE for a read is suppressed. WRITE continues to completion (stores are committed). Roll-back in IDLE/DONE: no effect on state.
- rdy=0: all registers hold, including mem_wr/mem_a; resume exactly where frozen.

## Timing
- Edge 0 = accepting edge; cycle k lies between edge k and k+1.
- n-byte read: mem_a=A+k in cycle k (k<n); last byte captured edge n+1; done high in cycle n+1. Word fetch: done in cycle 5.
- n-byte store: bytes written cycles 0..n-1; done high in cycle n (plus IO stall cycles).
- Earliest next accept: edge n+3 after a read, edge n+2 after a store.
- done is exactly one cycle wide; requester deasserts req at the edge ending the done cycle.

## Test plan
- Word fetch IF_addr=0x100, RAM bytes 13,00,00,00 -> mem_a 0x100..0x103 cycles 0-3, IF_done cycle 5, IF_data=0x00000013.
- Simultaneous IF_req and LSB_req after reset -> LSB granted first, IF granted next; repeat with both held -> grants alternate IF/LSB.
- Store half 0xBEEF to 0xFFFFFFFF -> writes EF to 0xFFFFFFFF, BE to 0x00000000, LSB_done cycle 2.
- Store byte to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 during stall, single write after release, LSB_done one cycle later.
- roll_back during word fetch cycle 2 -> no IF_done, state IDLE; roll_back during store -> store completes, LSB_done asserted.
- rst pulled low mid-READ (async) -> all outputs 0 immediately; rdy=0 for 4 cycles mid-load -> load completes with correct data, latency extended by 4.
